// File: rtl/instr_sequencer_pkg.sv
// Shared instruction-format definitions for the sequencer and the compute cores:
// opcode classes, halt-decode field positions and the sequencer state encoding.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    OPC_LOAD = 2'b00,
    OPC_ALU2 = 2'b01,
    OPC_ALU1 = 2'b10,
    OPC_MISC = 2'b11
  } opclass_e;

  localparam int CLASS_MSB = 15;
  localparam int CLASS_LSB = 14;
  localparam int HALT_BIT  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // A halt is a misc-class word with the halt flag set.
  function automatic logic is_halt(input logic [15:0] word);
    return (opclass_e'(word[CLASS_MSB:CLASS_LSB]) == OPC_MISC) && word[HALT_BIT];
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: synchronous write, asynchronous read, no reset so contents
// survive a sequencer reset.
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// SIMD instruction sequencer: runs the stored program once per start, broadcasting
// one registered opcode per cycle with an execute qualifier, stalled by hold.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH   = 16,
  parameter int OPCODE_WIDTH = 16,
  localparam int AW = $clog2(PROG_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog_we,
  input  logic [AW-1:0]           prog_addr,
  input  logic [OPCODE_WIDTH-1:0] prog_data,
  input  logic                    start,
  input  logic                    hold,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    execute,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           pc
);

  localparam logic [AW:0] END_ADDR = (AW+1)'(PROG_DEPTH);

  seq_state_e              state_q, state_d;
  logic [AW:0]             nxt_q, nxt_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [AW-1:0]           pc_q, pc_d;
  logic                    execute_q, execute_d;
  logic                    done_q, done_d;

  logic [AW-1:0]           fetch_addr;
  logic [OPCODE_WIDTH-1:0] fetch_word;
  logic                    fetch_halt;
  logic                    at_end;

  prog_mem #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (OPCODE_WIDTH)
  ) u_prog_mem (
    .clk     (clk),
    .we_i    (prog_we && (state_q == ST_IDLE)),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (fetch_addr),
    .rdata_o (fetch_word)
  );

  // nxt_q is one bit wider than pc so running off the end is visible without wrapping.
  assign fetch_addr = (state_q == ST_RUN) ? nxt_q[AW-1:0] : '0;
  assign fetch_halt = is_halt(fetch_word[15:0]);
  assign at_end     = (nxt_q == END_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (!hold && fetch_halt) ? ST_IDLE : ST_RUN;
      ST_RUN:  if (!hold && (at_end || fetch_halt)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Under hold nothing advances; the word fetched at nxt_q is issued once hold drops.
  always_comb begin
    opcode_d  = opcode_q;
    pc_d      = pc_q;
    nxt_d     = nxt_q;
    execute_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opcode_d = fetch_word;
          pc_d     = '0;
          nxt_d    = '0;
          if (!hold) begin
            execute_d = !fetch_halt;
            done_d    = fetch_halt;
            nxt_d     = (AW+1)'(1);
          end
        end
      end
      ST_RUN: begin
        if (!hold) begin
          if (at_end) begin
            done_d = 1'b1;
          end else begin
            opcode_d  = fetch_word;
            pc_d      = fetch_addr;
            execute_d = !fetch_halt;
            done_d    = fetch_halt;
            nxt_d     = nxt_q + (AW+1)'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q  <= '0;
      pc_q      <= '0;
      nxt_q     <= '0;
      execute_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      opcode_q  <= opcode_d;
      pc_q      <= pc_d;
      nxt_q     <= nxt_d;
      execute_q <= execute_d;
      done_q    <= done_d;
    end
  end

  assign opcode  = opcode_q;
  assign pc      = pc_q;
  assign execute = execute_q;
  assign done    = done_q;
  assign busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a reference model of the program memory
// pushes per-cycle expectations into a scoreboard that is drained as the run proceeds.
module tb_instr_sequencer;

  typedef struct {
    logic [15:0] op;
    logic [3:0]  pc;
    logic        ex;
    logic        dn;
    logic        bz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic        hold;
  logic [15:0] opcode;
  logic        execute;
  logic        busy;
  logic        done;
  logic [3:0]  pc;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] model_mem [16];
  exp_t        sb [$];

  instr_sequencer #(
    .PROG_DEPTH   (16),
    .OPCODE_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .hold      (hold),
    .opcode    (opcode),
    .execute   (execute),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic m_halt(input logic [15:0] w);
    return (w[15:14] == 2'b11) && w[4];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a[3:0];
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic push(input logic [15:0] op, input int a, input logic ex, input logic dn,
                      input logic bz);
    exp_t e;
    e.op = op;
    e.pc = a[3:0];
    e.ex = ex;
    e.dn = dn;
    e.bz = bz;
    sb.push_back(e);
  endtask

  // Expected cycle-by-cycle outputs for one run of the model program.
  task automatic push_run(input int hold_pc, input int hold_n, input bit tail);
    int a = 0;
    logic [15:0] w = '0;
    while (a < 16) begin
      w = model_mem[a];
      if (m_halt(w)) break;
      push(w, a, 1'b1, 1'b0, 1'b1);
      if (a == hold_pc)
        for (int k = 0; k < hold_n; k++) push(w, a, 1'b0, 1'b0, 1'b1);
      a++;
    end
    if (a == 16) begin
      a = 15;
      w = model_mem[15];
    end
    push(w, a, 1'b0, 1'b1, 1'b0);
    if (tail) push(w, a, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_run(input string name, input int hold_pc, input int hold_n, input int junk_i,
                        input bit pulse_start, input bit chain_next);
    exp_t e;
    int   n;
    push_run(hold_pc, hold_n, !chain_next);
    n = sb.size();
    if (pulse_start) begin
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = sb.pop_front();
      chk($sformatf("%s[%0d].opcode", name, i), 32'(opcode), 32'(e.op));
      chk($sformatf("%s[%0d].pc", name, i), 32'(pc), 32'(e.pc));
      chk($sformatf("%s[%0d].execute", name, i), 32'(execute), 32'(e.ex));
      chk($sformatf("%s[%0d].done", name, i), 32'(done), 32'(e.dn));
      chk($sformatf("%s[%0d].busy", name, i), 32'(busy), 32'(e.bz));
      hold    = (i >= hold_pc) && (i < hold_pc + hold_n);
      prog_we = (i == junk_i);
      start   = (i == junk_i) || (chain_next && (i == n - 1));
      if (i < n - 1 || chain_next) tick();
    end
    hold    = 1'b0;
    prog_we = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;
    hold      = 1'b0;
    repeat (2) tick();
    chk("reset.opcode", 32'(opcode), 32'h0);
    chk("reset.pc", 32'(pc), 32'h0);
    chk("reset.execute", 32'(execute), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();

    // Short program ending in a halt, then an immediate back-to-back rerun.
    load(0, 16'h0205);
    load(1, 16'h4A20);
    load(2, 16'hC010);
    do_run("halt_run", -1, 0, -1, 1'b1, 1'b1);
    do_run("b2b_run", -1, 0, -1, 1'b0, 1'b0);

    // Full memory with no halt, including near-miss halt encodings.
    for (int i = 0; i < 16; i++) load(i, 16'h3000 + 16'(i) * 16'h0111);
    load(5, 16'hC00F);
    load(7, 16'h8010);
    load(9, 16'hFFEF);
    do_run("full_run", -1, 0, -1, 1'b1, 1'b0);
    do_run("hold_run", 1, 3, -1, 1'b1, 1'b0);

    // Write and start attempts during a run must be ignored.
    prog_addr = 4'd0;
    prog_data = 16'h1234;
    do_run("busy_run", -1, 0, 2, 1'b1, 1'b0);
    do_run("mem0_kept", -1, 0, -1, 1'b1, 1'b0);

    // A halt word arriving while hold is asserted waits for hold to drop.
    load(3, 16'hC010);
    do_run("hold_halt", 2, 2, -1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_run.pc", 32'(pc), 32'h2);
    chk("mid_run.execute", 32'(execute), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.opcode", 32'(opcode), 32'h0);
    chk("async_rst.pc", 32'(pc), 32'h0);
    chk("async_rst.execute", 32'(execute), 32'h0);
    chk("async_rst.busy", 32'(busy), 32'h0);
    chk("async_rst.done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_run("after_rst", -1, 0, -1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
